// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory between instruction-fetch and data ports.
// Latency: grant one cycle after request, strobes combinational from owner; backpressure: owner sees mem_waitrequest, loser held at waitrequest=1.
module mips_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        timeout_err,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]      TIMEOUT_DATA = 32'hDEADBEEF;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;   // 1 = data port owned the last transaction
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q, proto_err_d;
    logic             d_req;
    logic             grant_d;

    assign d_req       = d_read | d_write;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        timeout_err_d  = timeout_err_q;
        proto_err_d    = proto_err_q;
        grant_d        = 1'b0;
        mem_address    = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'h0;
        mem_writedata  = 32'h0;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        i_readdata     = mem_readdata;
        d_readdata     = mem_readdata;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                // On a tie the port that did not win last time takes the bus.
                grant_d = d_req && (!i_read || !last_grant_q);
                if (grant_d) begin
                    state_d      = BUSY_D;
                    last_grant_d = 1'b1;
                    if (d_read && d_write) begin
                        proto_err_d = 1'b1;
                    end
                end else if (i_read) begin
                    state_d      = BUSY_I;
                    last_grant_d = 1'b0;
                end
            end

            BUSY_I: begin
                mem_address    = i_address;
                mem_read       = i_read;
                mem_byteenable = 4'hF;
                if (i_read && mem_waitrequest && cnt_q == TIMEOUT_VAL) begin
                    mem_read      = 1'b0;
                    i_waitrequest = 1'b0;
                    i_readdata    = TIMEOUT_DATA;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    i_waitrequest = mem_waitrequest;
                    if (!i_read || !mem_waitrequest) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            BUSY_D: begin
                mem_address    = d_address;
                mem_read       = d_read && !d_write;   // simultaneous read+write forwards the write only
                mem_write      = d_write;
                mem_byteenable = d_byteenable;
                mem_writedata  = d_writedata;
                if (d_req && mem_waitrequest && cnt_q == TIMEOUT_VAL) begin
                    mem_read      = 1'b0;
                    mem_write     = 1'b0;
                    d_waitrequest = 1'b0;
                    d_readdata    = TIMEOUT_DATA;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    d_waitrequest = mem_waitrequest;
                    if (!d_req || !mem_waitrequest) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: expected read data queued at request, compared at handshake.
module tb_mips_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        timeout_err;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {is_data_port, expected readdata}
    logic [32:0] e;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
        .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .timeout_err(timeout_err), .proto_err(proto_err)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic sb_pop(output logic [32:0] ent);
        if (exp_q.size() == 0) ent = 'x;
        else ent = exp_q.pop_front();
    endtask

    task automatic test_reset();
        nxt(); #1;
        checks++;
        if ({mem_read, mem_write, i_waitrequest, d_waitrequest, timeout_err, proto_err} !== 6'b001100) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b",
                {mem_read, mem_write, i_waitrequest, d_waitrequest, timeout_err, proto_err}, 6'b001100);
        end
        nxt(); rst_n = 1'b1; #1;
        checks++;
        if ({mem_read, mem_write, i_waitrequest, d_waitrequest} !== 4'b0011) begin
            errors++; $display("FAIL idle_after_reset: got %b expected %b",
                {mem_read, mem_write, i_waitrequest, d_waitrequest}, 4'b0011);
        end
    endtask

    task automatic test_reset_mid();
        nxt(); d_read = 1'b1; d_address = 32'h40; d_byteenable = 4'hF; mem_waitrequest = 1'b1; #1;
        checks++;
        if ({mem_read, d_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL rm_idle: got %b expected %b", {mem_read, d_waitrequest}, 2'b01);
        end
        nxt(); #1;
        checks++;
        if ({mem_read, mem_write, d_waitrequest, i_waitrequest} !== 4'b1011) begin
            errors++; $display("FAIL rm_busy_d: got %b expected %b",
                {mem_read, mem_write, d_waitrequest, i_waitrequest}, 4'b1011);
        end
        checks++;
        if (mem_address !== 32'h40) begin
            errors++; $display("FAIL rm_addr: got %h expected %h", mem_address, 32'h40);
        end
        nxt(); rst_n = 1'b0; #1;
        checks++;
        if ({mem_read, mem_write, i_waitrequest, d_waitrequest, timeout_err, proto_err} !== 6'b001100) begin
            errors++; $display("FAIL rm_reset: got %b expected %b",
                {mem_read, mem_write, i_waitrequest, d_waitrequest, timeout_err, proto_err}, 6'b001100);
        end
        d_read = 1'b0; mem_waitrequest = 1'b0;
        nxt(); rst_n = 1'b1; #1;
        nxt(); #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL rm_after: got %b expected %b", {mem_read, mem_write}, 2'b00);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        nxt();
        i_read = 1'b1; i_address = 32'h200;
        d_write = 1'b1; d_address = 32'h100; d_writedata = 32'h5; d_byteenable = 4'hF;
        mem_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) nxt();
            rd = 32'h1234_0000 | 32'(k);
            mem_readdata = rd;
            if (k % 2 == 1) exp_q.push_back({1'b0, rd});
            #1;
            checks++;
            if ({mem_read, mem_write} !== 2'b00) begin
                errors++; $display("FAIL b2b_idle%0d: got %b expected %b", k, {mem_read, mem_write}, 2'b00);
            end
            nxt(); #1;
            if (k % 2 == 0) begin
                checks++;
                if ({mem_write, mem_read, d_waitrequest, i_waitrequest} !== 4'b1001) begin
                    errors++; $display("FAIL b2b_grant_d%0d: got %b expected %b", k,
                        {mem_write, mem_read, d_waitrequest, i_waitrequest}, 4'b1001);
                end
                checks++;
                if ({mem_address, mem_writedata, mem_byteenable} !== {32'h100, 32'h5, 4'hF}) begin
                    errors++; $display("FAIL b2b_wr%0d: got %h/%h/%h expected 100/5/f", k,
                        mem_address, mem_writedata, mem_byteenable);
                end
            end else begin
                checks++;
                if ({mem_read, mem_write, i_waitrequest, d_waitrequest} !== 4'b1001) begin
                    errors++; $display("FAIL b2b_grant_i%0d: got %b expected %b", k,
                        {mem_read, mem_write, i_waitrequest, d_waitrequest}, 4'b1001);
                end
                checks++;
                if ({mem_address, mem_byteenable} !== {32'h200, 4'hF}) begin
                    errors++; $display("FAIL b2b_rd%0d: got %h/%h expected 200/f", k, mem_address, mem_byteenable);
                end
                sb_pop(e);
                checks++;
                if (i_readdata !== e[31:0]) begin
                    errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", k, i_readdata, e[31:0]);
                end
            end
        end
        nxt(); i_read = 1'b0; d_write = 1'b0; #1;
    endtask

    task automatic test_instr_read();
        nxt();
        i_read = 1'b1; i_address = 32'hBFC0_0000; mem_waitrequest = 1'b0; mem_readdata = 32'h8C02_0000;
        exp_q.push_back({1'b0, 32'h8C02_0000});
        #1;
        checks++;
        if ({mem_read, i_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL ird_n: got %b expected %b", {mem_read, i_waitrequest}, 2'b01);
        end
        nxt(); #1;
        checks++;
        if ({mem_read, mem_write, i_waitrequest, d_waitrequest} !== 4'b1001) begin
            errors++; $display("FAIL ird_n1: got %b expected %b",
                {mem_read, mem_write, i_waitrequest, d_waitrequest}, 4'b1001);
        end
        checks++;
        if ({mem_address, mem_byteenable} !== {32'hBFC0_0000, 4'hF}) begin
            errors++; $display("FAIL ird_addr: got %h/%h expected bfc00000/f", mem_address, mem_byteenable);
        end
        sb_pop(e);
        checks++;
        if (i_readdata !== e[31:0]) begin
            errors++; $display("FAIL ird_rdata: got %h expected %h", i_readdata, e[31:0]);
        end
        nxt(); i_read = 1'b0; #1;
    endtask

    task automatic test_wait_states();
        nxt();
        d_read = 1'b1; d_address = 32'h300; d_byteenable = 4'h3; mem_waitrequest = 1'b1;
        mem_readdata = 32'hCAFE_0001;
        exp_q.push_back({1'b1, 32'hCAFE_0001});
        #1;
        for (int c = 0; c < 3; c++) begin
            nxt(); #1;
            checks++;
            if ({mem_read, d_waitrequest, i_waitrequest, mem_byteenable} !== 7'b111_0011) begin
                errors++; $display("FAIL ws_stall%0d: got %b expected %b", c,
                    {mem_read, d_waitrequest, i_waitrequest, mem_byteenable}, 7'b111_0011);
            end
        end
        nxt(); mem_waitrequest = 1'b0; #1;
        checks++;
        if ({mem_read, d_waitrequest, i_waitrequest} !== 3'b101) begin
            errors++; $display("FAIL ws_done: got %b expected %b", {mem_read, d_waitrequest, i_waitrequest}, 3'b101);
        end
        sb_pop(e);
        checks++;
        if (d_readdata !== e[31:0]) begin
            errors++; $display("FAIL ws_rdata: got %h expected %h", d_readdata, e[31:0]);
        end
        nxt(); d_read = 1'b0; #1;
    endtask

    task automatic test_timeout();
        nxt();
        d_read = 1'b1; d_address = 32'h400; d_byteenable = 4'hF; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        #1;
        for (int c = 0; c < TO; c++) begin
            nxt(); #1;
            checks++;
            if ({mem_read, d_waitrequest, timeout_err} !== 3'b110) begin
                errors++; $display("FAIL to_stall%0d: got %b expected %b", c,
                    {mem_read, d_waitrequest, timeout_err}, 3'b110);
            end
        end
        nxt(); #1;
        checks++;
        if ({mem_read, d_waitrequest, i_waitrequest} !== 3'b001) begin
            errors++; $display("FAIL to_release: got %b expected %b", {mem_read, d_waitrequest, i_waitrequest}, 3'b001);
        end
        sb_pop(e);
        checks++;
        if (d_readdata !== e[31:0]) begin
            errors++; $display("FAIL to_rdata: got %h expected %h", d_readdata, e[31:0]);
        end
        nxt();
        d_read = 1'b0; mem_waitrequest = 1'b0; i_read = 1'b1; i_address = 32'h500; mem_readdata = 32'h1111_0000;
        exp_q.push_back({1'b0, 32'h1111_0000});
        #1;
        checks++;
        if ({timeout_err, mem_read, i_waitrequest} !== 3'b101) begin
            errors++; $display("FAIL to_idle: got %b expected %b", {timeout_err, mem_read, i_waitrequest}, 3'b101);
        end
        nxt(); #1;
        checks++;
        if ({mem_read, i_waitrequest, mem_address} !== {2'b10, 32'h500}) begin
            errors++; $display("FAIL to_regrant: got %b/%h expected 10/500", {mem_read, i_waitrequest}, mem_address);
        end
        sb_pop(e);
        checks++;
        if (i_readdata !== e[31:0]) begin
            errors++; $display("FAIL to_rdata2: got %h expected %h", i_readdata, e[31:0]);
        end
        nxt(); i_read = 1'b0; #1;
    endtask

    task automatic test_proto();
        nxt();
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h600; d_writedata = 32'hA5A5_5A5A;
        d_byteenable = 4'hF; mem_waitrequest = 1'b0;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL pe_before: got %b expected %b", proto_err, 1'b0);
        end
        nxt(); #1;
        checks++;
        if ({mem_write, mem_read, d_waitrequest, proto_err} !== 4'b1001) begin
            errors++; $display("FAIL pe_grant: got %b expected %b", {mem_write, mem_read, d_waitrequest, proto_err}, 4'b1001);
        end
        checks++;
        if (mem_writedata !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL pe_wdata: got %h expected %h", mem_writedata, 32'hA5A5_5A5A);
        end
        nxt(); d_read = 1'b0; d_write = 1'b0;
        nxt(); nxt(); #1;
        checks++;
        if ({proto_err, timeout_err, mem_read, mem_write} !== 4'b1100) begin
            errors++; $display("FAIL pe_sticky: got %b expected %b", {proto_err, timeout_err, mem_read, mem_write}, 4'b1100);
        end
    endtask

    task automatic test_drop();
        nxt(); i_read = 1'b1; i_address = 32'h700; mem_waitrequest = 1'b1; #1;
        nxt(); #1;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL drop_busy: got %b expected %b", mem_read, 1'b1);
        end
        i_read = 1'b0; #1;
        checks++;
        if ({mem_read, i_waitrequest, d_waitrequest} !== 3'b011) begin
            errors++; $display("FAIL drop_comb: got %b expected %b", {mem_read, i_waitrequest, d_waitrequest}, 3'b011);
        end
        nxt();
        d_read = 1'b1; d_address = 32'h704; mem_waitrequest = 1'b0; mem_readdata = 32'h77;
        exp_q.push_back({1'b1, 32'h77});
        #1;
        nxt(); #1;
        checks++;
        if ({mem_read, d_waitrequest, mem_address} !== {2'b10, 32'h704}) begin
            errors++; $display("FAIL drop_regrant: got %b/%h expected 10/704", {mem_read, d_waitrequest}, mem_address);
        end
        sb_pop(e);
        checks++;
        if (d_readdata !== e[31:0]) begin
            errors++; $display("FAIL drop_rdata: got %h expected %h", d_readdata, e[31:0]);
        end
        nxt(); d_read = 1'b0; #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_byteenable = '0; d_writedata = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0;
        test_reset();
        test_reset_mid();
        test_back_to_back();
        test_instr_read();
        test_wait_states();
        test_timeout();
        test_proto();
        test_drop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drained: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
